timer_mch_core: RTL and testbench

//  Multi-channel timer counter core; generalises single-channel TCR/TDR/TCMP timer to NUM_CH channels.
//  Per channel: 2^div_val prescaler, CNT_W-bit up-counter, compare match, free/periodic/one-shot modes.

---
 rtl/timer_mch_pkg.sv | 21 ++
 rtl/timer_mch_chan.sv | 117 +++++++++++
 rtl/timer_mch_core.sv | 74 +++++++
 tb/tb_timer_mch_core.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_mch_pkg.sv
// Shared types and helpers for the multi-channel timer core.
// Mode encoding, default prescale exponent limit and its clamp.
package timer_mch_pkg;

    typedef enum logic [1:0] {
        MODE_FREE     = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    localparam int DIV_MAX_C = 8;

    function automatic logic [31:0] clamp_div(
        input logic [31:0] v,
        input logic [31:0] mx
    );
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/timer_mch_chan.sv
// One timer channel: 2^n prescaler, up-counter, compare match,
// sticky pending flag and free/periodic/one-shot behaviour.
module timer_mch_chan
    import timer_mch_pkg::*;
#(
    parameter int CNT_W   = 64,
    parameter int DIV_W   = 4,
    parameter int DIV_MAX = DIV_MAX_C
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ch_en,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    input  logic [1:0]       mode,
    input  logic             cnt_wr,
    input  logic [CNT_W-1:0] cnt_wdata,
    input  logic [CNT_W-1:0] cmp_val,
    input  logic             irq_clr,
    input  logic             halt,
    output logic [CNT_W-1:0] cnt_val,
    output logic             irq_pend,
    output logic             oneshot_done
);

    localparam int PW = (DIV_MAX > 0) ? DIV_MAX : 1;

    mode_e            md;
    logic [31:0]      dv;
    logic [PW-1:0]    presc;
    logic [PW-1:0]    term;
    logic             div_en_q;
    logic [DIV_W-1:0] div_val_q;
    logic             ch_en_q;
    logic             presc_clr;
    logic             tick;
    logic             at_cmp;
    logic             match;

    assign md   = mode_e'(mode);
    assign dv   = clamp_div(32'(div_val), 32'(DIV_MAX));
    assign term = ~({PW{1'b1}} << dv);

    assign at_cmp = (cnt_val == cmp_val);
    assign match  = at_cmp && ch_en;

    // Any reconfiguration restarts the divide period from zero.
    assign presc_clr = !ch_en || !div_en || cnt_wr
                     || (div_en != div_en_q)
                     || (div_val != div_val_q);

    assign tick = ch_en && !halt && !oneshot_done
               && (!div_en || (presc == term));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            div_en_q  <= 1'b0;
            div_val_q <= '0;
            ch_en_q   <= 1'b0;
        end else begin
            div_en_q  <= div_en;
            div_val_q <= div_val;
            ch_en_q   <= ch_en;
            if (presc_clr) begin
                presc <= '0;
            end else if (tick) begin
                presc <= '0;
            end else if (!halt && !oneshot_done) begin
                presc <= presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_val      <= '0;
            oneshot_done <= 1'b0;
        end else if (cnt_wr) begin
            cnt_val      <= cnt_wdata;
            oneshot_done <= 1'b0;
        end else begin
            if (ch_en_q && !ch_en) begin
                oneshot_done <= 1'b0;
            end
            if (tick) begin
                case (md)
                    MODE_PERIODIC: begin
                        cnt_val <= at_cmp ? '0 : cnt_val + 1'b1;
                    end
                    MODE_ONESHOT: begin
                        if (at_cmp) begin
                            oneshot_done <= 1'b1;
                        end else begin
                            cnt_val <= cnt_val + 1'b1;
                        end
                    end
                    default: begin
                        cnt_val <= cnt_val + 1'b1;
                    end
                endcase
            end
        end
    end

    // A live match outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_pend <= 1'b0;
        end else if (match) begin
            irq_pend <= 1'b1;
        end else if (irq_clr) begin
            irq_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_mch_core.sv
// Multi-channel timer core; TIMER_HALT_EN adds a dbg_halt freeze input.
// Holds the channel array, the registered irq mask and the irq OR-reduce.
module timer_mch_core
    import timer_mch_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 64,
    parameter int DIV_W   = 4,
    parameter int DIV_MAX = DIV_MAX_C
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
`ifdef TIMER_HALT_EN
    input  logic                    dbg_halt,
`endif
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       div_en,
    input  logic [NUM_CH*DIV_W-1:0] div_val,
    input  logic [NUM_CH*2-1:0]     mode,
    input  logic [NUM_CH-1:0]       cnt_wr,
    input  logic [NUM_CH*CNT_W-1:0] cnt_wdata,
    input  logic [NUM_CH*CNT_W-1:0] cmp_val,
    input  logic [NUM_CH-1:0]       irq_en,
    input  logic [NUM_CH-1:0]       irq_clr,
    output logic [NUM_CH*CNT_W-1:0] cnt_val,
    output logic [NUM_CH-1:0]       irq_pend,
    output logic [NUM_CH-1:0]       oneshot_done,
    output logic                    irq
);

    logic              halt;
    logic [NUM_CH-1:0] irq_en_q;

`ifdef TIMER_HALT_EN
    assign halt = dbg_halt;
`else
    assign halt = 1'b0;
`endif

    // irq is built only from flops so the APB side sees no comb path.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            irq_en_q <= '0;
        end else begin
            irq_en_q <= irq_en;
        end
    end

    assign irq = |(irq_pend & irq_en_q);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_mch_chan #(
            .CNT_W   (CNT_W),
            .DIV_W   (DIV_W),
            .DIV_MAX (DIV_MAX)
        ) u_chan (
            .clk          (sys_clk),
            .rst_n        (sys_rst_n),
            .ch_en        (ch_en[i]),
            .div_en       (div_en[i]),
            .div_val      (div_val[i*DIV_W +: DIV_W]),
            .mode         (mode[i*2 +: 2]),
            .cnt_wr       (cnt_wr[i]),
            .cnt_wdata    (cnt_wdata[i*CNT_W +: CNT_W]),
            .cmp_val      (cmp_val[i*CNT_W +: CNT_W]),
            .irq_clr      (irq_clr[i]),
            .halt         (halt),
            .cnt_val      (cnt_val[i*CNT_W +: CNT_W]),
            .irq_pend     (irq_pend[i]),
            .oneshot_done (oneshot_done[i])
        );
    end

endmodule

// File: tb/tb_timer_mch_core.sv
// Directed bench for timer_mch_core with a cycle-tagged scoreboard.
// Expectations are queued when stimulus is driven, checked at negedges.
module tb_timer_mch_core;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 64;
    localparam int DIV_W  = 4;

    localparam int S_CNT0  = 0;
    localparam int S_PEND0 = 1;
    localparam int S_DONE0 = 2;
    localparam int S_IRQ   = 3;
    localparam int S_CNT1  = 4;
    localparam int S_PEND1 = 5;

    logic                    sys_clk;
    logic                    sys_rst_n;
    logic                    dbg_halt;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       div_en;
    logic [NUM_CH*DIV_W-1:0] div_val;
    logic [NUM_CH*2-1:0]     mode;
    logic [NUM_CH-1:0]       cnt_wr;
    logic [NUM_CH*CNT_W-1:0] cnt_wdata;
    logic [NUM_CH*CNT_W-1:0] cmp_val;
    logic [NUM_CH-1:0]       irq_en;
    logic [NUM_CH-1:0]       irq_clr;
    logic [NUM_CH*CNT_W-1:0] cnt_val;
    logic [NUM_CH-1:0]       irq_pend;
    logic [NUM_CH-1:0]       oneshot_done;
    logic                    irq;

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cur   = 0;
    int   total = 0;
    int   bad   = 0;

    timer_mch_core #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DIV_W  (DIV_W)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
`ifdef TIMER_HALT_EN
        .dbg_halt     (dbg_halt),
`endif
        .ch_en        (ch_en),
        .div_en       (div_en),
        .div_val      (div_val),
        .mode         (mode),
        .cnt_wr       (cnt_wr),
        .cnt_wdata    (cnt_wdata),
        .cmp_val      (cmp_val),
        .irq_en       (irq_en),
        .irq_clr      (irq_clr),
        .cnt_val      (cnt_val),
        .irq_pend     (irq_pend),
        .oneshot_done (oneshot_done),
        .irq          (irq)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [63:0] obs(input int sig);
        case (sig)
            S_CNT0:  return cnt_val[63:0];
            S_PEND0: return 64'(irq_pend[0]);
            S_DONE0: return 64'(oneshot_done[0]);
            S_IRQ:   return 64'(irq);
            S_CNT1:  return cnt_val[127:64];
            S_PEND1: return 64'(irq_pend[1]);
            default: return 64'hDEAD;
        endcase
    endfunction

    task automatic push(input string tag, input int sig,
                        input int d, input logic [63:0] v);
        exp_t e;
        e.cyc = cur + d;
        e.sig = sig;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        keep[$];
        exp_t        e;
        logic [63:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.cyc == cur) begin
                o = obs(e.sig);
                total++;
                assert (o === e.val) else begin
                    bad++;
                    $error("FAIL %s @%0d: observed=%h expected=%h",
                           e.tag, cur, o, e.val);
                end
            end else begin
                keep.push_back(e);
            end
        end
        sb = keep;
    endtask

    task automatic step();
        @(negedge sys_clk);
        cur++;
        drain();
    endtask

    task automatic push_seq(input string tag, input int sig,
                            input logic [63:0] v[]);
        foreach (v[i]) push(tag, sig, i + 1, v[i]);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        dbg_halt  = 1'b0;
        ch_en     = '0;
        div_en    = '0;
        div_val   = '0;
        mode      = '0;
        cnt_wr    = '0;
        cnt_wdata = '0;
        cmp_val   = '0;
        cmp_val[63:0] = 64'h1000_0000;
        irq_en    = '0;
        irq_clr   = '0;

        push("rst_cnt0", S_CNT0, 1, 64'd0);
        push("rst_pend0", S_PEND0, 1, 64'd0);
        push("rst_done0", S_DONE0, 1, 64'd0);
        push("rst_irq", S_IRQ, 1, 64'd0);
        push("rst_cnt1", S_CNT1, 1, 64'd0);
        step();
        sys_rst_n = 1'b1;

        div_en[0]     = 1'b1;
        div_val[3:0]  = 4'd1;
        step();
        step();

        // divide by 2
        push_seq("div2", S_CNT0, '{64'd0, 64'd1, 64'd1, 64'd2, 64'd2, 64'd3});
        ch_en[0] = 1'b1;
        repeat (6) step();

        // div_val ignored with divider off
        push_seq("nodiv", S_CNT0, '{64'd4, 64'd5, 64'd6, 64'd7});
        div_en[0]    = 1'b0;
        div_val[3:0] = 4'd5;
        repeat (4) step();

        // clamped exponent: one tick per 256 cycles
        cnt_wr[0]       = 1'b1;
        cnt_wdata[63:0] = 64'd0;
        div_en[0]       = 1'b1;
        div_val[3:0]    = 4'd12;
        push("div256_ld", S_CNT0, 1, 64'd0);
        push("div256_pre", S_CNT0, 256, 64'd0);
        push("div256_tick", S_CNT0, 257, 64'd1);
        step();
        cnt_wr[0] = 1'b0;
        repeat (256) step();

        // ch_en low holds the count
        ch_en[0]  = 1'b0;
        div_en[0] = 1'b0;
        push("hold", S_CNT0, 1, 64'd1);
        push("hold", S_CNT0, 2, 64'd1);
        repeat (2) step();

        // periodic, cmp 3
        mode[1:0]       = 2'd1;
        cmp_val[63:0]   = 64'd3;
        cnt_wr[0]       = 1'b1;
        cnt_wdata[63:0] = 64'd0;
        push("per_ld", S_CNT0, 1, 64'd0);
        step();
        cnt_wr[0] = 1'b0;
        ch_en[0]  = 1'b1;
        push_seq("per", S_CNT0, '{64'd1, 64'd2, 64'd3, 64'd0,
                                  64'd1, 64'd2, 64'd3, 64'd0});
        push("per_pend_lo", S_PEND0, 3, 64'd0);
        push("per_pend_hi", S_PEND0, 4, 64'd1);
        push("per_irq_mask", S_IRQ, 4, 64'd0);
        repeat (8) step();

        irq_en[0] = 1'b1;
        push("per_irq_on", S_IRQ, 1, 64'd1);
        step();
        irq_clr[0] = 1'b1;
        push("clr_pend", S_PEND0, 1, 64'd0);
        push("clr_irq", S_IRQ, 1, 64'd0);
        push("clr_cnt", S_CNT0, 1, 64'd2);
        step();
        irq_clr[0] = 1'b0;
        push("pre_match", S_CNT0, 1, 64'd3);
        step();
        irq_clr[0] = 1'b1;
        push("set_beats_clr", S_PEND0, 1, 64'd1);
        push("per_wrap", S_CNT0, 1, 64'd0);
        step();
        irq_clr[0] = 1'b0;
        ch_en[0]   = 1'b0;
        step();

        // one-shot, cmp 5
        mode[1:0]       = 2'd2;
        cmp_val[63:0]   = 64'd5;
        cnt_wr[0]       = 1'b1;
        cnt_wdata[63:0] = 64'd0;
        irq_clr[0]      = 1'b1;
        step();
        cnt_wr[0]  = 1'b0;
        irq_clr[0] = 1'b0;
        ch_en[0]   = 1'b1;
        push_seq("os", S_CNT0, '{64'd1, 64'd2, 64'd3, 64'd4,
                                 64'd5, 64'd5, 64'd5});
        push("os_done_lo", S_DONE0, 5, 64'd0);
        push("os_done_hi", S_DONE0, 6, 64'd1);
        push("os_done_hi", S_DONE0, 7, 64'd1);
        push("os_pend_lo", S_PEND0, 5, 64'd0);
        push("os_pend_hi", S_PEND0, 6, 64'd1);
        repeat (7) step();

        ch_en[0] = 1'b0;
        push("os_fall_done", S_DONE0, 1, 64'd0);
        push("os_fall_cnt", S_CNT0, 1, 64'd5);
        step();
        ch_en[0]        = 1'b1;
        cnt_wr[0]       = 1'b1;
        cnt_wdata[63:0] = 64'd0;
        push("os_reload", S_CNT0, 1, 64'd0);
        push("os_reload_done", S_DONE0, 1, 64'd0);
        step();
        cnt_wr[0] = 1'b0;
        push("os_restart", S_CNT0, 1, 64'd1);
        push("os_restart", S_CNT0, 2, 64'd2);
        repeat (2) step();

        // free-run wrap at the top of the range
        mode[1:0]       = 2'd0;
        cmp_val[63:0]   = 64'h1000;
        cnt_wr[0]       = 1'b1;
        cnt_wdata[63:0] = 64'hFFFF_FFFF_FFFF_FFFE;
        irq_clr[0]      = 1'b1;
        push("wrap_ld", S_CNT0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        push("ch1_idle", S_CNT1, 1, 64'd0);
        step();
        cnt_wr[0]  = 1'b0;
        irq_clr[0] = 1'b0;
        push_seq("wrap", S_CNT0, '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1});
        push("wrap_noflag", S_PEND0, 3, 64'd0);
        repeat (3) step();

        // channel 1 alone; its match is masked from irq
        ch_en = 2'b10;
        push_seq("ch0_idle", S_CNT0, '{64'd1, 64'd1, 64'd1});
        push_seq("ch1_run", S_CNT1, '{64'd1, 64'd2, 64'd3});
        push("ch1_pend", S_PEND1, 1, 64'd1);
        push("ch1_masked", S_IRQ, 3, 64'd0);
        repeat (3) step();
        irq_en = 2'b11;
        push("ch1_irq", S_IRQ, 1, 64'd1);
        push("ch1_run", S_CNT1, 1, 64'd4);
        step();

`ifdef TIMER_HALT_EN
        dbg_halt = 1'b1;
        for (int i = 1; i <= 10; i++) push("halt", S_CNT1, i, 64'd4);
        push("resume", S_CNT1, 11, 64'd5);
        push("resume", S_CNT1, 12, 64'd6);
        repeat (10) step();
        dbg_halt = 1'b0;
        repeat (2) step();
`endif

        // asynchronous reset between clock edges
        #2;
        sys_rst_n = 1'b0;
        #1;
        push("arst_cnt0", S_CNT0, 0, 64'd0);
        push("arst_cnt1", S_CNT1, 0, 64'd0);
        push("arst_pend1", S_PEND1, 0, 64'd0);
        push("arst_done0", S_DONE0, 0, 64'd0);
        push("arst_irq", S_IRQ, 0, 64'd0);
        drain();
        step();
        sys_rst_n = 1'b1;
        push("post_rst", S_CNT1, 1, 64'd1);
        step();

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover: observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
